// File: rtl/imem_if.sv
// Instruction-memory request/grant/response bundle between the fetch stage and imem.
interface imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32 instruction fetch stage: one outstanding imem request, output slot plus one-entry skid,
// redirect flush with drain of a stale in-flight response.
//
// state   | meaning
// S_REQ   | request pc_q to imem, waiting for grant
// S_WAIT  | request granted, waiting for response
// S_HOLD  | response parked in skid, waiting for the output slot to free
// S_DRAIN | redirect left a stale response in flight; swallow it
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00400000,
  parameter logic [31:0] BUBBLE_INST = 32'h11111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stage1_rewrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  imem_if.master      imem,
  output logic [31:0] pc_out,
  output logic [31:0] pc_add4_out,
  output logic [31:0] inst_out,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc_add4_q, pc_add4_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_valid_q, skid_valid_d;

  logic        consume;
  logic        slot_free;
  logic [31:0] redirect_target;
  logic        unused_pc_lsbs;

  assign consume         = valid_q & ~stage1_rewrite & ~redirect;
  assign slot_free       = ~valid_q | consume;
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign unused_pc_lsbs  = ^redirect_pc[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_req_d     = pc_req_q;
    pc_out_d     = pc_out_q;
    pc_add4_d    = pc_add4_q;
    inst_d       = inst_q;
    valid_d      = valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_valid_d = skid_valid_q;

    if (redirect) begin
      pc_d         = redirect_target;
      pc_out_d     = RESET_PC;
      pc_add4_d    = 32'h0;
      inst_d       = BUBBLE_INST;
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
      // A granted-but-unanswered request will still return data; it must be swallowed.
      if ((state_q == S_WAIT && !imem.imem_rvalid) ||
          (state_q == S_REQ && imem.imem_gnt) ||
          (state_q == S_DRAIN && !imem.imem_rvalid))
        state_d = S_DRAIN;
      else
        state_d = S_REQ;
    end else begin
      if (consume) begin
        pc_out_d  = RESET_PC;
        pc_add4_d = 32'h0;
        inst_d    = BUBBLE_INST;
        valid_d   = 1'b0;
      end
      case (state_q)
        S_REQ: begin
          if (imem.imem_gnt) begin
            pc_req_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            if (slot_free) begin
              pc_out_d  = pc_req_q;
              pc_add4_d = pc_req_q + 32'd4;
              inst_d    = imem.imem_rdata;
              valid_d   = 1'b1;
              state_d   = S_REQ;
            end else begin
              skid_pc_d    = pc_req_q;
              skid_inst_d  = imem.imem_rdata;
              skid_valid_d = 1'b1;
              state_d      = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free && skid_valid_q) begin
            pc_out_d     = skid_pc_q;
            pc_add4_d    = skid_pc_q + 32'd4;
            inst_d       = skid_inst_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
            state_d      = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem.imem_rvalid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      pc_req_q     <= RESET_PC;
      pc_out_q     <= RESET_PC;
      pc_add4_q    <= 32'h0;
      inst_q       <= BUBBLE_INST;
      valid_q      <= 1'b0;
      skid_pc_q    <= RESET_PC;
      skid_inst_q  <= BUBBLE_INST;
      skid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_req_q     <= pc_req_d;
      pc_out_q     <= pc_out_d;
      pc_add4_q    <= pc_add4_d;
      inst_q       <= inst_d;
      valid_q      <= valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // Request decoded from registered state only, so no input reaches imem_req/imem_addr.
  assign imem.imem_req  = (state_q == S_REQ);
  assign imem.imem_addr = pc_q;

  assign pc_out      = pc_out_q;
  assign pc_add4_out = pc_add4_q;
  assign inst_out    = inst_q;
  assign fetch_valid = valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model plus in-order scoreboard of expected fetches.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC    = 32'h00400000;
  localparam logic [31:0] BUBBLE_INST = 32'h11111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stage1_rewrite = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] pc_out, pc_add4_out, inst_out;
  logic        fetch_valid;

  imem_if bus ();

  if_fetch_unit #(.RESET_PC(RESET_PC), .BUBBLE_INST(BUBBLE_INST)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stage1_rewrite (stage1_rewrite),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .pc_out         (pc_out),
    .pc_add4_out    (pc_add4_out),
    .inst_out       (inst_out),
    .fetch_valid    (fetch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_data = 32'h0;
  int          lat = 1;
  logic        gnt_en = 1'b1;
  logic        redir_on_rv = 1'b0;
  logic        last_g, last_rv;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h00000013;
  endfunction

  task automatic tick();
    logic g, rv;
    exp_t e;
    @(negedge clk);
    rv = mem_pend && (mem_cnt == 0);
    if (redir_on_rv && rv) begin
      redirect       = 1'b1;
      stage1_rewrite = 1'b1;
      redir_on_rv    = 1'b0;
    end
    g = bus.imem_req && gnt_en && rst_n;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_data : 32'h0;

    if (bus.imem_req) check_val("imem_addr", bus.imem_addr, exp_pc);
    if (fetch_valid) begin
      if (sb.size() > 0) begin
        check_val("pc_out", pc_out, sb[0].pc);
        check_val("pc_add4_out", pc_add4_out, sb[0].pc + 32'd4);
        check_val("inst_out", inst_out, sb[0].inst);
      end else begin
        check_val("unexpected_valid", {31'h0, fetch_valid}, 32'h0);
      end
    end else begin
      check_val("bubble_inst", inst_out, BUBBLE_INST);
      check_val("bubble_pc", pc_out, RESET_PC);
    end

    if (mem_pend && mem_cnt != 0) mem_cnt--;
    if (rv) mem_pend = 1'b0;
    if (!rst_n) begin
      sb.delete();
      mem_pend = 1'b0;
      exp_pc   = RESET_PC;
    end else begin
      if (g) begin
        mem_pend = 1'b1;
        mem_cnt  = lat - 1;
        mem_data = mem_fn(bus.imem_addr);
      end
      if (redirect) begin
        sb.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (g) begin
          sb.push_back('{exp_pc, mem_fn(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
        if (fetch_valid && !stage1_rewrite && sb.size() > 0) begin
          e = sb.pop_front();
          n_out++;
        end
      end
    end
    last_g  = g;
    last_rv = rv;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_fv"}, {31'h0, fetch_valid}, 32'h0);
    check_val({tag, "_pc"}, pc_out, RESET_PC);
    check_val({tag, "_add4"}, pc_add4_out, 32'h0);
    check_val({tag, "_inst"}, inst_out, BUBBLE_INST);
    check_val({tag, "_req"}, {31'h0, bus.imem_req}, 32'h1);
    check_val({tag, "_addr"}, bus.imem_addr, RESET_PC);
  endtask

  initial begin
    int k;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Sequential fetch, zero-wait memory
    tick();
    check_val("first_gnt", {31'h0, last_g}, 32'h1);
    tick();
    check_val("latency_fv", {31'h0, fetch_valid}, 32'h1);
    check_val("latency_req", {31'h0, bus.imem_req}, 32'h1);
    n_out = 0;
    repeat (20) tick();
    check_val("throughput", n_out, 10);

    // Decode stall until the skid fills
    k = 0;
    while (!fetch_valid && k < 4) begin tick(); k++; end
    check_val("stall_start_fv", {31'h0, fetch_valid}, 32'h1);
    stage1_rewrite = 1'b1;
    repeat (6) tick();
    check_val("hold_no_req", {31'h0, bus.imem_req}, 32'h0);
    check_val("hold_fv", {31'h0, fetch_valid}, 32'h1);
    stage1_rewrite = 1'b0;
    tick();
    check_val("skid_presented", {31'h0, fetch_valid}, 32'h1);
    repeat (6) tick();

    // Redirect while waiting; stale response must be drained
    lat = 4;
    k = 0;
    do begin tick(); k++; end while (!last_g && k < 10);
    check_val("drain_gnt", {31'h0, last_g}, 32'h1);
    mem_data    = 32'hDEADBEEF;
    redirect    = 1'b1;
    redirect_pc = 32'h00400100;
    lat         = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("drain_no_req", {31'h0, bus.imem_req}, 32'h0);
      check_val("drain_fv", {31'h0, fetch_valid}, 32'h0);
      tick();
    end
    check_val("drain_req", {31'h0, bus.imem_req}, 32'h1);
    check_val("drain_addr", bus.imem_addr, 32'h00400100);
    k = 0;
    while (!fetch_valid && k < 10) begin tick(); k++; end
    check_val("target_inst", inst_out, mem_fn(32'h00400100));
    repeat (4) tick();

    // Redirect coinciding with rvalid and stall
    redirect_pc = 32'h00400200;
    redir_on_rv = 1'b1;
    k = 0;
    while (redir_on_rv && k < 10) begin tick(); k++; end
    check_val("rvredir_fired", {31'h0, redir_on_rv}, 32'h0);
    check_val("rvredir_fv", {31'h0, fetch_valid}, 32'h0);
    check_val("rvredir_req", {31'h0, bus.imem_req}, 32'h1);
    check_val("rvredir_addr", bus.imem_addr, 32'h00400200);
    stage1_rewrite = 1'b0;
    repeat (6) tick();

    // Redirect to an unaligned top-of-memory address: wrap-around
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFE;
    tick();
    k = 0;
    while (!bus.imem_req && k < 10) begin tick(); k++; end
    check_val("wrap_addr", bus.imem_addr, 32'hFFFFFFFC);
    k = 0;
    while (!fetch_valid && k < 10) begin tick(); k++; end
    check_val("wrap_pc", pc_out, 32'hFFFFFFFC);
    check_val("wrap_add4", pc_add4_out, 32'h00000000);
    check_val("wrap_next_addr", bus.imem_addr, 32'h00000000);
    repeat (4) tick();

    // Reset while a request is outstanding
    lat = 3;
    k = 0;
    do begin tick(); k++; end while (!last_g && k < 10);
    check_val("rst_gnt", {31'h0, last_g}, 32'h1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    lat = 1;
    repeat (8) tick();

    // Randomised traffic: grant gaps, latencies, stalls, redirects
    for (int i = 0; i < 400; i++) begin
      gnt_en         = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 3);
      stage1_rewrite = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
      end
      tick();
    end
    stage1_rewrite = 1'b0;
    gnt_en = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
